mode_select: RTL and testbench



---
 rtl/mode_select.sv | 158 +++++++++++++++
 tb/tb_mode_select.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_select.sv
// Front-panel mode selector: two debounced pushbuttons step the frequency and
// modulation mode codes up or down (per sw_dir) unless sw_lock freezes them.
module mode_select #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_freq_n,
    input  logic       key_mod_n,
    input  logic       sw_dir,
    input  logic       sw_lock,
    output logic [2:0] fmode,
    output logic [1:0] mmode,
    output logic       mode_changed
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order: {sw_lock, sw_dir, key_mod_n, key_freq_n}; idle keys read high.
    localparam logic [3:0] SYNC_RST = 4'b0011;

    logic [3:0] async_in;
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [1:0] step;

    assign async_in = {sw_lock, sw_dir, key_mod_n, key_freq_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= SYNC_RST;
            sync2_reg <= SYNC_RST;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            db_state_t        state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             pressed;
            logic             step_fire;
            logic             step_reg;

            assign pressed  = ~sync2_reg[gi];
            assign step[gi] = step_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    step_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    step_reg  <= step_fire;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    IDLE: begin
                        cnt_next = '0;
                        if (pressed) begin
                            state_next = PRESS_WAIT;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        cnt_next = '0;
                        if (!pressed) begin
                            state_next = RELEASE_WAIT;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed) begin
                            state_next = HELD;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            // The step is registered so the mode changes one edge after acceptance.
            always_comb begin
                step_fire = (state_reg == PRESS_WAIT) && pressed && (cnt_reg == CNT_LAST);
            end
        end
    endgenerate

    logic [2:0] fmode_reg;
    logic [1:0] mmode_reg;
    logic       changed_reg;
    logic       dir_sync;
    logic       lock_sync;

    assign dir_sync  = sync2_reg[2];
    assign lock_sync = sync2_reg[3];

    // A locked step is simply dropped; the debounce FSM has already moved on to HELD.
    always_ff @(posedge clk) begin
        if (reset) begin
            fmode_reg   <= 3'd0;
            mmode_reg   <= 2'd0;
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= 1'b0;
            if (!lock_sync && (step != 2'b00)) begin
                changed_reg <= 1'b1;
                if (step[0]) begin
                    fmode_reg <= dir_sync ? fmode_reg - 3'd1 : fmode_reg + 3'd1;
                end
                if (step[1]) begin
                    mmode_reg <= dir_sync ? mmode_reg - 2'd1 : mmode_reg + 2'd1;
                end
            end
        end
    end

    assign fmode        = fmode_reg;
    assign mmode        = mmode_reg;
    assign mode_changed = changed_reg;

endmodule

// File: tb/tb_mode_select.sv
// Scoreboard bench for mode_select with DEBOUNCE_CYCLES=4: stimulus pushes the
// expected (edge, fmode, mmode) of every mode change; a monitor checks each cycle.
module tb_mode_select;

    logic       clk;
    logic       reset;
    logic       key_freq_n;
    logic       key_mod_n;
    logic       sw_dir;
    logic       sw_lock;
    logic [2:0] fmode;
    logic [1:0] mmode;
    logic       mode_changed;

    mode_select #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_freq_n   (key_freq_n),
        .key_mod_n    (key_mod_n),
        .sw_dir       (sw_dir),
        .sw_lock      (sw_lock),
        .fmode        (fmode),
        .mmode        (mmode),
        .mode_changed (mode_changed)
    );

    typedef struct {
        int       cyc;
        logic [2:0] f;
        logic [1:0] m;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    logic [2:0] mf = 3'd0;
    logic [1:0] mm = 2'd0;
    logic [2:0] last_f = 3'd0;
    logic [1:0] last_m = 2'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                checks++;
                if (fmode !== 3'd0 || mmode !== 2'd0 || mode_changed !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_state cyc=%0d got f=%b m=%b chg=%b expected f=000 m=00 chg=0",
                             cyc, fmode, mmode, mode_changed);
                end
            end else begin
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                    e = sb_q.pop_front();
                    checks++;
                    fails++;
                    $display("FAIL missing_change expected at cyc=%0d f=%b m=%b, mode_changed never pulsed (now cyc=%0d f=%b m=%b)",
                             e.cyc, e.f, e.m, cyc, fmode, mmode);
                end
                if (mode_changed === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_change cyc=%0d got f=%b m=%b expected no mode_changed",
                                 cyc, fmode, mmode);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.cyc != cyc || fmode !== e.f || mmode !== e.m) begin
                            fails++;
                            $display("FAIL step got cyc=%0d f=%b m=%b expected cyc=%0d f=%b m=%b",
                                     cyc, fmode, mmode, e.cyc, e.f, e.m);
                        end
                    end
                end else begin
                    checks++;
                    if (mode_changed !== 1'b0 || fmode !== last_f || mmode !== last_m) begin
                        fails++;
                        $display("FAIL stable cyc=%0d got f=%b m=%b chg=%b expected f=%b m=%b chg=0",
                                 cyc, fmode, mmode, mode_changed, last_f, last_m);
                    end
                end
            end
            last_f = fmode;
            last_m = mmode;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int at_cyc);
        exp_t e;
        e.cyc = at_cyc;
        e.f   = mf;
        e.m   = mm;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        mf = 3'd0;
        mm = 2'd0;
        wait_neg(2);
    endtask

    // Called just after a falling edge; keys go low now, change lands 7 edges later.
    task automatic press(input bit pf, input bit pm, input int hold, input bit expect_step);
        if (expect_step) begin
            if (pf) mf = sw_dir ? mf - 3'd1 : mf + 3'd1;
            if (pm) mm = sw_dir ? mm - 2'd1 : mm + 2'd1;
            push_exp(cyc + 7);
        end
        if (pf) key_freq_n = 1'b0;
        if (pm) key_mod_n = 1'b0;
        wait_neg(hold);
        key_freq_n = 1'b1;
        key_mod_n  = 1'b1;
        wait_neg(8);
    endtask

    initial begin
        int c;
        reset      = 1'b1;
        key_freq_n = 1'b1;
        key_mod_n  = 1'b1;
        sw_dir     = 1'b0;
        sw_lock    = 1'b0;
        wait_neg(1);
        do_reset();

        // Long hold: exactly one step, no auto-repeat.
        press(1'b1, 1'b0, 20, 1'b1);

        // Glitches of 2 and 3 cycles are rejected; 4 stable cycles are accepted.
        press(1'b0, 1'b1, 2, 1'b0);
        press(1'b0, 1'b1, 3, 1'b0);
        press(1'b0, 1'b1, 4, 1'b1);

        // Eight increments wrap fmode back to 000, then one decrement wraps to 111.
        do_reset();
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 6, 1'b1);
        sw_dir = 1'b1;
        wait_neg(3);
        press(1'b1, 1'b0, 6, 1'b1);

        // Lock discards the step; releasing it mid-hold does not replay the press.
        do_reset();
        sw_dir  = 1'b0;
        sw_lock = 1'b1;
        wait_neg(3);
        key_mod_n = 1'b0;
        wait_neg(12);
        sw_lock = 1'b0;
        wait_neg(10);
        key_mod_n = 1'b1;
        wait_neg(8);
        press(1'b0, 1'b1, 6, 1'b1);

        // Both keys together, decrementing from reset: one shared pulse.
        do_reset();
        sw_dir = 1'b1;
        wait_neg(3);
        press(1'b1, 1'b1, 6, 1'b1);

        // Reset while key_freq_n is in PRESS_WAIT with cnt=2; held key re-debounces.
        sw_dir = 1'b0;
        wait_neg(3);
        c = cyc;
        key_freq_n = 1'b0;
        wait_neg(4);
        reset = 1'b1;
        wait_neg(1);
        reset = 1'b0;
        mf = 3'd1;
        mm = 2'd0;
        push_exp(c + 12);
        wait_neg(15);
        key_freq_n = 1'b1;
        wait_neg(10);

        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
